syncnd_filt_ppp: RTL
====================

# syncnd_filt_ppp

Parametrised multi-bit clock-domain-crossing synchroniser: a DEPTH-stage flop chain per bit, a programmable stability (deglitch) filter, and per-bit change pulses. It sits on the receive side of every asynchronous control/status crossing, replacing fixed single-bit 3-stage synchronisers. Reset value is per-bit programmable, so set-type and clear-type synchronisers collapse into one cell. Bus-filter mode delivers multi-bit quasi-static values (configuration, gray-coded pointers at rest) only after the whole bus has settled.

## Interface
- WIDTH, 1: number of synchronised bits.
- DEPTH, 3: synchroniser chain stages; legal 2..8.
- RST_VAL, all ones ([WIDTH-1:0]): value loaded into chain, q and history flops at reset.
- FILTER, 0: stability cycles required before q updates; 0 bypasses the filter; legal 0..255.
- BUS_FILT, 0: 0 = each bit filtered independently; 1 = one filter for the whole bus.
- clk  input  1  receive-domain clock.
- reset_  input  1  reset; one clock; reset is synchronous and active-low.
- d  input  WIDTH  asynchronous input.
- q  output  WIDTH  synchronised, filtered value.
- q_edge  output  WIDTH  one-cycle pulse on each bit of q that changed this cycle.
- filt_busy  output  1  high while any filter counter is non-zero.

## Operation
- Chain: s[0] <= d; s[i] <= s[i-1]; s_last = s[DEPTH-1]. No logic between chain flops.
- FILTER=0: q = s_last (no extra flop).
- FILTER>0, BUS_FILT=0, per bit: if s_last==q, cnt<=0; else if cnt==FILTER-1, q<=s_last and cnt<=0; else cnt<=cnt+1.
- FILTER>0, BUS_FILT=1: s_prev <= s_last (WIDTH flops). If s_last==q or s_last!=s_prev, cnt<=0; else if cnt==FILTER-1, q<=s_last (all bits at once) and cnt<=0; else cnt<=cnt+1.
- Counter width $clog2(FILTER+1); it never wraps, because it is cleared on reaching FILTER-1.
- q_d <= q; q_edge = q ^ q_d.
- filt_busy = OR of all cnt != 0; tied 0 when FILTER=0.
- Synchronous reset (reset_==0 at a rising edge): s[*], s_prev, q, q_d <= RST_VAL; cnt <= 0. Reset overrides every other update, including a reset asserted mid-filter. After reset: q=RST_VAL, q_edge=0, filt_busy=0.
- An input glitch shorter than FILTER cycles at s_last never reaches q.

## Timing
- Edge 1 is the first rising edge that samples a new d value.
- FILTER=0: q changes after edge DEPTH.
- Per-bit filter: q changes after edge DEPTH+FILTER, provided s_last stays constant throughout.
- Bus filter: q changes after edge DEPTH+FILTER+1; the extra cycle comes from the s_prev compare.
- q_edge is high for exactly the first cycle q holds the new value.
- A change of s_last back to q during the count clears cnt on the next edge; q is unchanged.
- In bus mode, a further bus change during the count restarts it from 0.
- d changing every cycle: q holds indefinitely when FILTER>=2.

## Structure
- Shared package sync_pkg:
  - SYNC_FILT_BIT=0 and SYNC_FILT_BUS=1 constants.
  - SYNC_DEPTH_MIN=2 and SYNC_DEPTH_MAX=8.
  - SYNC_FILTER_MAX=255.
- Elaboration-time checks on DEPTH and FILTER ranges.
- One sub-module, sync_filt_cnt, holds the counter, compare and load enable:
  - instanced WIDTH times with 1-bit data when BUS_FILT=0;
  - instanced once with WIDTH-bit data when BUS_FILT=1.
- Chain flops carry the team's synchroniser-cell preserve attribute.

## Test plan
- Reset: WIDTH=4, RST_VAL=4'b1010; hold reset_ low 2 cycles with d=4'hF -> q=4'hA, q_edge=0, filt_busy=0; release -> q=4'hF after edge 3.
- Latency: DEPTH=3, FILTER=0, d 0->1 -> q=1 after edge 3, q_edge=1 that cycle only. DEPTH=5 -> q=1 after edge 5.
- Deglitch: DEPTH=2, FILTER=4, per-bit. A 3-cycle d pulse -> q stays 0, filt_busy seen high. A 4-cycle pulse -> q=1 after edge 6 for one...n cycles, then returns by the same rule.
- Bus settle: WIDTH=8, DEPTH=3, FILTER=2, BUS_FILT=1; d 8'h00->8'h0F, then 8'h3F one cycle later -> q jumps directly 8'h00->8'h3F after edge 7. q_edge=8'h3F; 8'h0F is never output.
- Reset mid-filter: FILTER=8, cnt=5, pulse reset_ low one cycle -> cnt=0, q=RST_VAL, no q_edge on reset release.
- Random async d against a reference model at DEPTH in {2,3,4}, FILTER in {0,1,3} -> q and q_edge match cycle-exactly.

Source files
------------

// File: rtl/sync_pkg.sv
// Shared constants for the receive-side CDC synchroniser family.
package sync_pkg;

  localparam int unsigned SYNC_FILT_BIT   = 0;
  localparam int unsigned SYNC_FILT_BUS   = 1;
  localparam int unsigned SYNC_DEPTH_MIN  = 2;
  localparam int unsigned SYNC_DEPTH_MAX  = 8;
  localparam int unsigned SYNC_FILTER_MAX = 255;

endpackage

// File: rtl/sync_filt_cnt.sv
// Stability counter: asserts load_o once s_i has differed from q_i, and been
// stable, for FILTER consecutive cycles.
module sync_filt_cnt
  import sync_pkg::*;
#(
  parameter int unsigned W      = 1,
  parameter int unsigned FILTER = 1
) (
  input  logic         clk,
  input  logic         reset_,
  input  logic [W-1:0] s_i,
  input  logic [W-1:0] q_i,
  input  logic         stable_i,
  output logic         load_o,
  output logic         busy_o
);

  localparam int unsigned   CW       = $clog2(FILTER + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Cleared on reaching CNT_LAST, so the counter never wraps.
  always_comb begin
    cnt_d  = cnt_q;
    load_o = 1'b0;
    if ((s_i == q_i) || !stable_i) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      load_o = 1'b1;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = |cnt_q;

endmodule

// File: rtl/syncnd_filt_ppp.sv
// Multi-bit CDC synchroniser: DEPTH-stage chain per bit, optional per-bit or
// whole-bus stability filter, and per-bit change pulses on the output.
module syncnd_filt_ppp
  import sync_pkg::*;
#(
  parameter int unsigned      WIDTH    = 1,
  parameter int unsigned      DEPTH    = 3,
  parameter logic [WIDTH-1:0] RST_VAL  = '1,
  parameter int unsigned      FILTER   = 0,
  parameter int unsigned      BUS_FILT = 0
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_edge,
  output logic             filt_busy
);

  if ((DEPTH < SYNC_DEPTH_MIN) || (DEPTH > SYNC_DEPTH_MAX)) begin : g_bad_depth
    $error("syncnd_filt_ppp: DEPTH must be within 2..8");
  end
  if (FILTER > SYNC_FILTER_MAX) begin : g_bad_filter
    $error("syncnd_filt_ppp: FILTER must be within 0..255");
  end
  if (BUS_FILT > SYNC_FILT_BUS) begin : g_bad_busfilt
    $error("syncnd_filt_ppp: BUS_FILT must be 0 or 1");
  end

  (* preserve *) logic [WIDTH-1:0] sync_q [DEPTH];
  logic [WIDTH-1:0] s_last;
  logic [WIDTH-1:0] q_dly_q;

  always_ff @(posedge clk) begin
    if (!reset_) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        sync_q[i] <= RST_VAL;
      end
    end else begin
      sync_q[0] <= d;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign s_last = sync_q[DEPTH-1];

  if (FILTER == 0) begin : g_nofilt
    assign q         = s_last;
    assign filt_busy = 1'b0;
  end else begin : g_filt
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] load_vec;
    logic             busy;

    if (BUS_FILT == SYNC_FILT_BUS) begin : g_bus
      logic [WIDTH-1:0] s_prev_q;
      logic             load;

      always_ff @(posedge clk) begin
        if (!reset_) begin
          s_prev_q <= RST_VAL;
        end else begin
          s_prev_q <= s_last;
        end
      end

      // Any bus movement since the previous cycle restarts the count.
      sync_filt_cnt #(
        .W      (WIDTH),
        .FILTER (FILTER)
      ) u_cnt (
        .clk      (clk),
        .reset_   (reset_),
        .s_i      (s_last),
        .q_i      (q_q),
        .stable_i (s_last == s_prev_q),
        .load_o   (load),
        .busy_o   (busy)
      );

      assign load_vec = {WIDTH{load}};
    end else begin : g_bit
      logic [WIDTH-1:0] busy_vec;

      for (genvar b = 0; b < WIDTH; b++) begin : g_lane
        sync_filt_cnt #(
          .W      (1),
          .FILTER (FILTER)
        ) u_cnt (
          .clk      (clk),
          .reset_   (reset_),
          .s_i      (s_last[b]),
          .q_i      (q_q[b]),
          .stable_i (1'b1),
          .load_o   (load_vec[b]),
          .busy_o   (busy_vec[b])
        );
      end

      assign busy = |busy_vec;
    end

    always_comb begin
      q_d = (load_vec & s_last) | (~load_vec & q_q);
    end

    always_ff @(posedge clk) begin
      if (!reset_) begin
        q_q <= RST_VAL;
      end else begin
        q_q <= q_d;
      end
    end

    assign q         = q_q;
    assign filt_busy = busy;
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      q_dly_q <= RST_VAL;
    end else begin
      q_dly_q <= q;
    end
  end

  assign q_edge = q ^ q_dly_q;

endmodule
